// File: rtl/decode_pkg.sv
// Shared decode constants and the per-lane result bundle.
// Used by decode_lane and decode_stage.
package decode_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] C_R    = 7'b1000000;
    localparam logic [6:0] C_I    = 7'b1100000;
    localparam logic [6:0] C_LUI  = 7'b1110000;
    localparam logic [6:0] C_LB   = 7'b1101011;
    localparam logic [6:0] C_LW   = 7'b1101010;
    localparam logic [6:0] C_SB   = 7'b0100101;
    localparam logic [6:0] C_SW   = 7'b0100100;
    localparam logic [6:0] C_ZERO = 7'b0000000;

    typedef struct packed {
        logic [6:0]  c_sig;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } lane_t;

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction decoder.
// Masked lanes produce an all-zero bundle.
module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        lane_valid,
    output lane_t       res
);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] u_imm;

    assign op    = instr[6:0];
    assign f3    = instr[14:12];
    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign u_imm = {instr[31:12], 12'b0};

    // decode opcode/funct3 into control word and immediate
    always_comb begin
        res = '0;
        if (lane_valid) begin
            res.rd  = instr[11:7];
            res.rs1 = instr[19:15];
            res.rs2 = instr[24:20];
            unique case (1'b1)
                op == OP_R: begin
                    res.c_sig = C_R;
                end
                op == OP_I: begin
                    res.c_sig = C_I;
                    res.imm   = i_imm;
                end
                op == OP_LUI: begin
                    res.c_sig = C_LUI;
                    res.imm   = u_imm;
                end
                op == OP_LOAD && f3 == F3_BYTE: begin
                    res.c_sig = C_LB;
                    res.imm   = i_imm;
                end
                op == OP_LOAD && f3 == F3_WORD: begin
                    res.c_sig = C_LW;
                    res.imm   = i_imm;
                end
                op == OP_STORE && f3 == F3_BYTE: begin
                    res.c_sig = C_SB;
                    res.imm   = s_imm;
                end
                op == OP_STORE && f3 == F3_WORD: begin
                    res.c_sig = C_SW;
                    res.imm   = s_imm;
                end
                default: begin
                    res.c_sig   = C_ZERO;
                    res.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: per-lane decoders feeding a
// main register M plus skid register S, valid/ready both sides.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DECODE_WIDTH = 2,
    parameter int PC_WIDTH     = 12,
    parameter int XLEN         = 32,
    parameter int C_SIG_WIDTH  = 7,
    parameter int SEQ_WIDTH    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PC_WIDTH-1:0]             in_pc,
    input  logic [32*DECODE_WIDTH-1:0]      in_instr,
    input  logic [DECODE_WIDTH-1:0]         in_lane_valid,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DECODE_WIDTH-1:0]         out_lane_valid,
    output logic [PC_WIDTH*DECODE_WIDTH-1:0] out_pc,
    output logic [C_SIG_WIDTH*DECODE_WIDTH-1:0] out_c_sig,
    output logic [XLEN*DECODE_WIDTH-1:0]    out_imm,
    output logic [5*DECODE_WIDTH-1:0]       out_rd,
    output logic [5*DECODE_WIDTH-1:0]       out_rs1,
    output logic [5*DECODE_WIDTH-1:0]       out_rs2,
    output logic [DECODE_WIDTH-1:0]         out_illegal,
    output logic [SEQ_WIDTH-1:0]            out_seq
);

    typedef struct packed {
        logic [DECODE_WIDTH-1:0]               lv;
        logic [DECODE_WIDTH-1:0][PC_WIDTH-1:0] pc;
        lane_t [DECODE_WIDTH-1:0]              lane;
        logic [SEQ_WIDTH-1:0]                  seq;
    } grp_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t                  state;
    state_t                  state_n;
    grp_t                    m_grp;
    grp_t                    s_grp;
    grp_t                    in_grp;
    lane_t [DECODE_WIDTH-1:0] dec;
    logic [SEQ_WIDTH-1:0]    seq_cnt;
    logic                    take_in;
    logic                    take_out;
    logic                    load_m_in;
    logic                    load_s_in;
    logic                    move_s;

    for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
        decode_lane u_lane (
            .instr      (in_instr[32*i +: 32]),
            .lane_valid (in_lane_valid[i]),
            .res        (dec[i])
        );
    end

    // assemble the incoming group with per-lane PCs and tag
    always_comb begin
        in_grp      = '0;
        in_grp.lv   = in_lane_valid;
        in_grp.lane = dec;
        in_grp.seq  = seq_cnt;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            in_grp.pc[i] = in_pc + PC_WIDTH'(4 * i);
        end
    end

    assign in_ready  = rst_n && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign take_in   = in_valid && in_ready && !flush;
    assign take_out  = out_valid && out_ready;

    // occupancy state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_n;
    end

    // next occupancy and register load selects
    always_comb begin
        state_n   = state;
        load_m_in = 1'b0;
        load_s_in = 1'b0;
        move_s    = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (take_in) begin
                        state_n   = ONE;
                        load_m_in = 1'b1;
                    end
                end
                ONE: begin
                    if (take_in && take_out) begin
                        load_m_in = 1'b1;
                    end else if (take_in) begin
                        state_n   = FULL;
                        load_s_in = 1'b1;
                    end else if (take_out) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (take_out) begin
                        state_n = ONE;
                        move_s  = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // group storage and tag counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_grp   <= '0;
            s_grp   <= '0;
            seq_cnt <= '0;
        end else begin
            if (load_m_in)   m_grp <= in_grp;
            else if (move_s) m_grp <= s_grp;
            if (load_s_in)   s_grp <= in_grp;
            if (take_in)     seq_cnt <= seq_cnt + SEQ_WIDTH'(1);
        end
    end

    assign out_lane_valid = m_grp.lv;
    assign out_pc         = m_grp.pc;
    assign out_seq        = m_grp.seq;

    for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_out
        assign out_c_sig[i*C_SIG_WIDTH +: C_SIG_WIDTH] =
            C_SIG_WIDTH'(m_grp.lane[i].c_sig);
        assign out_imm[i*XLEN +: XLEN] =
            XLEN'($signed(m_grp.lane[i].imm));
        assign out_rd[i*5 +: 5]   = m_grp.lane[i].rd;
        assign out_rs1[i*5 +: 5]  = m_grp.lane[i].rs1;
        assign out_rs2[i*5 +: 5]  = m_grp.lane[i].rs2;
        assign out_illegal[i]     = m_grp.lane[i].illegal;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered decode stage sitting between fetch and rename/dispatch. Each cycle it accepts a group of up to `DECODE_WIDTH` instructions and decodes each lane into a control-signal word, sign-extended immediate, register indices and an illegal-instruction flag. It presents the results through a one-cycle pipeline register backed by a skid buffer, with valid/ready handshakes on both sides, a flush input and a per-group sequence tag.

## Interface
- `DECODE_WIDTH`, 2: lanes per group (≥1).
- `PC_WIDTH`, 12: PC width.
- `XLEN`, 32: immediate width; instruction width fixed at 32.
- `C_SIG_WIDTH`, 7: control-signal word width.
- `SEQ_WIDTH`, 4: group sequence tag width.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input group valid.
- `in_ready`  out  1  stage can accept a group.
- `in_pc`  in  PC_WIDTH  PC of lane 0.
- `in_instr`  in  32*DECODE_WIDTH  lane i at bits [32i+31:32i].
- `in_lane_valid`  in  DECODE_WIDTH  per-lane valid mask.
- `flush`  in  1  discard all held and incoming groups.
- `out_valid`  out  1  output group valid.
- `out_ready`  in  1  consumer accepts the group.
- `out_lane_valid`  out  DECODE_WIDTH  registered lane mask.
- `out_pc`  out  PC_WIDTH*DECODE_WIDTH  lane i = in_pc + 4i, mod 2^PC_WIDTH.
- `out_c_sig`  out  C_SIG_WIDTH*DECODE_WIDTH  control word per lane.
- `out_imm`  out  XLEN*DECODE_WIDTH  immediate per lane.
- `out_rd`, `out_rs1`, `out_rs2`  out  5*DECODE_WIDTH each  instr[11:7], [19:15], [24:20].
- `out_illegal`  out  DECODE_WIDTH  unsupported encoding.
- `out_seq`  out  SEQ_WIDTH  tag of the group.

## Operation
- Control words:
  - R-type (0110011): 1000000.
  - I-type (0010011): 1100000.
  - LUI (0110111): 1110000.
  - Load (0000011): funct3 000 gives LB 1101011; 010 gives LW 1101010.
  - Store (0100011): funct3 000 gives SB 0100101; 010 gives SW 0100100.
- Any other opcode, or load/store with any other funct3: c_sig 0, illegal 1. The decode is fully combinational per lane and never holds a previous value.
- Immediates:
  - R: 0.
  - I/load: sext(instr[31:20]).
  - Store: sext({instr[31:25], instr[11:7]}).
  - LUI: {instr[31:12], 12'b0}.
  - Illegal: 0.
- Lanes with `in_lane_valid[i]`=0: c_sig, imm, rd/rs1/rs2 and illegal are all zero. The group is still transferred.
- Storage: main register M and skid register S, each holding a full decoded group, valid bit and tag.
  - Transfer in: `in_valid && in_ready && !flush`. The tag is `seq_cnt`, which then increments and wraps modulo 2^SEQ_WIDTH.
  - Transfer out: `out_valid && out_ready`.
- State (M.v, S.v) ∈ EMPTY(0,0), ONE(1,0), FULL(1,1):
  - EMPTY: transfer in moves to ONE.
  - ONE, in only: if out_ready, M is replaced and the state stays ONE. Otherwise the group goes to S and the state becomes FULL.
  - ONE, out only: moves to EMPTY.
  - FULL: `in_ready`=0. On transfer out, S moves to M and the state becomes ONE.
- `in_ready` = rst_n && !S.v. It is a registered-state function only and does not depend on `out_ready`.
- `out_valid` = M.v. Outputs are driven from M.
- Flush:
  - Clears M.v and S.v next cycle and drops any same-cycle input.
  - `seq_cnt` is not reset.
  - Flush wins over a simultaneous transfer in or out; the out transfer still counts as consumed by the consumer.

## Timing
- Latency is 1 cycle: a group accepted at edge n appears on `out_*` after edge n.
- Throughput is 1 group/cycle while `out_ready`=1.
- Ordering is strictly FIFO. M and S never reorder.
- Reset values:
  - `out_valid`=0, `in_ready`=0 while rst_n=0, `seq_cnt`=0.
  - All `out_*` data = 0, including `out_lane_valid`, `out_illegal` and `out_seq`.
- Reset mid-operation: all held groups are dropped and nothing transfers in that cycle.
- Out-side data are stable while `out_valid && !out_ready`.

## Structure
- Package `decode_pkg` holds:
  - opcode constants, `F3_BYTE`/`F3_WORD`;
  - all seven control-word constants plus the zero/illegal word;
  - the lane bundle struct typedef (c_sig, imm, rd, rs1, rs2, illegal).
- Sub-module `decode_lane` is a purely combinational single-instruction decoder, instantiated DECODE_WIDTH times via generate. The M/S registers and the FSM live in `decode_stage`.

## Test plan
- `add` 0x002081B3 on lane 0 and `addi` 0xFFF00293 on lane 1 at in_pc 0x010 → next cycle:
  - lane 0: c_sig 1000000, rd 3, rs1 1, rs2 2, imm 0;
  - lane 1: c_sig 1100000, imm 0xFFFFFFFF;
  - out_pc 0x010/0x014, out_seq 0.
- `sw` 0x0020A423 → c_sig 0100100, imm 8. `lui` 0x123450B7 → c_sig 1110000, imm 0x12345000, rd 1.
- Unsupported load funct3 0x00109083 → c_sig 0, imm 0, illegal 1. A masked lane → all zero and illegal 0.
- Backpressure, with in_valid held and out_ready=0 for 3 cycles:
  - two groups are accepted;
  - in_ready drops the cycle after the second acceptance;
  - on release, outputs appear with seq 0, 1, 2 in order and none are lost.
- Flush with the state FULL and in_valid=1 → out_valid=0 next cycle and the input is dropped. The next accepted group carries seq 2.
- PC wrap: in_pc 0xFFC, DECODE_WIDTH=2 → out_pc lanes 0xFFC, 0x000. After 16 groups, out_seq wraps 15 → 0.
